// File: rtl/firebird7_in_gate1_tessent_tdr_ctl_w3.sv
// IJTAG test data register for the gate1 data-mux override: captures the functional
// value for observation and drives select/data, rejecting updates after a mis-sized scan.
module firebird7_in_gate1_tessent_tdr_ctl_w3 #(
    parameter int WIDTH = 3
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] functional_data_in,
    output logic             ijtag_select,
    output logic [WIDTH-1:0] ijtag_data_out,
    output logic             len_err
);

    localparam int L  = WIDTH + 2;
    localparam int CW = $clog2(L + 2);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURED,
        SHIFTING,
        ARMED
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [L-1:0]    sr;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic            cap;
    logic            shf;
    logic            upd;
    logic            good_upd;

    assign cap = ijtag_sel & ijtag_ce;
    assign shf = ijtag_sel & ijtag_se & ~ijtag_ce;
    assign upd = ijtag_sel & ijtag_ue & ~ijtag_ce & ~ijtag_se;

    // Shift count saturates one past the chain length so any over-shift stays visible.
    assign cnt_inc = (cnt == CW'(L + 1)) ? cnt : cnt + CW'(1);

    assign ijtag_so = sr[0];

    always_comb begin
        state_nxt = state;
        good_upd  = 1'b0;
        if (cap) begin
            state_nxt = CAPTURED;
        end else if (shf) begin
            case (state)
                CAPTURED, SHIFTING: state_nxt = (cnt_inc == CW'(L)) ? ARMED : SHIFTING;
                ARMED:              state_nxt = SHIFTING;
                default:            state_nxt = IDLE;
            endcase
        end else if (upd) begin
            good_upd  = (state == ARMED);
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            state          <= IDLE;
            sr             <= '0;
            cnt            <= '0;
            ijtag_select   <= 1'b0;
            ijtag_data_out <= '0;
            len_err        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cap) begin
                sr  <= {len_err, functional_data_in, ijtag_select};
                cnt <= '0;
            end else if (shf) begin
                sr  <= {ijtag_si, sr[L-1:1]};
                cnt <= cnt_inc;
            end else if (upd) begin
                cnt <= '0;
                // The status bit scanned in is observe-only and deliberately dropped.
                if (good_upd) begin
                    ijtag_select   <= sr[0];
                    ijtag_data_out <= sr[WIDTH:1];
                    len_err        <= 1'b0;
                end else begin
                    len_err        <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_ctl_w3.sv
// Bench for the gate1 override TDR: directed test-plan steps followed by randomized
// scan episodes, all checked against a shift-count reference model.
module tb_firebird7_in_gate1_tessent_tdr_ctl_w3;

    logic       tck = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       ce;
    logic       se;
    logic       ue;
    logic       si;
    logic       so;
    logic [2:0] fdi;
    logic       o_sel;
    logic [2:0] o_data;
    logic       o_err;

    int checks = 0;
    int errors = 0;

    // Reference model: bits of the chain, outputs, and shifts counted since a capture.
    logic [4:0] m_sr;
    logic       m_sel;
    logic [2:0] m_data;
    logic       m_err;
    int         m_shifts;
    bit         m_fresh;

    always #5 tck = ~tck;

    firebird7_in_gate1_tessent_tdr_ctl_w3 #(.WIDTH(3)) dut (
        .ijtag_tck          (tck),
        .ijtag_reset        (rst_n),
        .ijtag_sel          (sel),
        .ijtag_ce           (ce),
        .ijtag_se           (se),
        .ijtag_ue           (ue),
        .ijtag_si           (si),
        .ijtag_so           (so),
        .functional_data_in (fdi),
        .ijtag_select       (o_sel),
        .ijtag_data_out     (o_data),
        .len_err            (o_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic s, input logic c, input logic e,
                              input logic u, input logic d, input logic [2:0] f);
        if (!r) begin
            m_sr = '0; m_sel = 1'b0; m_data = '0; m_err = 1'b0;
            m_shifts = 0; m_fresh = 1'b0;
        end else if (s && c) begin
            m_sr = {m_err, f, m_sel};
            m_shifts = 0;
            m_fresh = 1'b1;
        end else if (s && e) begin
            m_sr = {d, m_sr[4:1]};
            m_shifts++;
        end else if (s && u) begin
            if (m_fresh && m_shifts == 5) begin
                m_sel  = m_sr[0];
                m_data = m_sr[3:1];
                m_err  = 1'b0;
            end else begin
                m_err  = 1'b1;
            end
            m_fresh = 1'b0;
            m_shifts = 0;
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic c, input logic e,
                       input logic u, input logic d);
        rst_n = r; sel = s; ce = c; se = e; ue = u; si = d;
        @(posedge tck);
        model_step(r, s, c, e, u, d, fdi);
        #1;
        chk("so", 32'(so), 32'(m_sr[0]));
        chk("select", 32'(o_sel), 32'(m_sel));
        chk("data", 32'(o_data), 32'(m_data));
        chk("len_err", 32'(o_err), 32'(m_err));
    endtask

    task automatic cap_c();  cyc(1, 1, 1, 0, 0, 0); endtask
    task automatic sh(input logic d); cyc(1, 1, 0, 1, 0, d); endtask
    task automatic up();     cyc(1, 1, 0, 0, 1, 0); endtask

    logic [4:0] exp_so;
    logic [4:0] wbits;
    logic       snap_sel;
    logic [2:0] snap_data;
    logic       snap_err;
    logic       snap_so;
    int         n;
    int         r8;

    initial begin
        rst_n = 1'b0; sel = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0; fdi = '0;
        m_sr = '0; m_sel = 1'b0; m_data = '0; m_err = 1'b0; m_shifts = 0; m_fresh = 1'b0;
        #2;

        // Reset with random enables
        for (int i = 0; i < 2; i++)
            cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        chk("rst_select", 32'(o_sel), 0);
        chk("rst_data", 32'(o_data), 0);
        chk("rst_so", 32'(so), 0);
        chk("rst_len_err", 32'(o_err), 0);

        // Capture/observe
        fdi = 3'b101;
        cap_c();
        exp_so = 5'b01010;
        for (int i = 0; i < 5; i++) begin
            chk("obs_so", 32'(so), 32'(exp_so[i]));
            sh(1'b0);
        end

        // Good write: 1,0,1,1,0 first bit first
        wbits = 5'b01101;
        cap_c();
        for (int i = 0; i < 5; i++) sh(wbits[i]);
        up();
        chk("good_select", 32'(o_sel), 1);
        chk("good_data", 32'(o_data), 32'(3'b110));
        chk("good_len_err", 32'(o_err), 0);

        // Short scan
        cap_c();
        for (int i = 0; i < 4; i++) sh(1'b0);
        up();
        chk("short_select", 32'(o_sel), 1);
        chk("short_data", 32'(o_data), 32'(3'b110));
        chk("short_len_err", 32'(o_err), 1);

        // Long scan
        cap_c();
        for (int i = 0; i < 6; i++) sh(1'b0);
        up();
        chk("long_select", 32'(o_sel), 1);
        chk("long_data", 32'(o_data), 32'(3'b110));
        chk("long_len_err", 32'(o_err), 1);

        // Status bit observed as fifth bit out
        cap_c();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) chk("status_so", 32'(so), 1);
            sh(1'b0);
        end

        // Deselect: nothing moves
        snap_sel = o_sel; snap_data = o_data; snap_err = o_err; snap_so = so;
        cyc(1, 0, 1, 0, 0, 1);
        cyc(1, 0, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 1, 1);
        cyc(1, 0, 1, 1, 1, 1);
        chk("desel_select", 32'(o_sel), 32'(snap_sel));
        chk("desel_data", 32'(o_data), 32'(snap_data));
        chk("desel_len_err", 32'(o_err), 32'(snap_err));
        chk("desel_so", 32'(so), 32'(snap_so));

        // Capture and update together: capture wins
        fdi = 3'b011;
        cyc(1, 1, 1, 0, 1, 0);
        chk("prio_select", 32'(o_sel), 32'(snap_sel));
        chk("prio_data", 32'(o_data), 32'(snap_data));
        chk("prio_so", 32'(so), 32'(snap_sel));
        sh(1'b0);
        chk("prio_cap_bit1", 32'(so), 1);

        // Reset mid-shift then update
        cap_c();
        for (int i = 0; i < 3; i++) sh(1'b1);
        cyc(0, 1, 0, 1, 0, 1);
        up();
        chk("midrst_select", 32'(o_sel), 0);
        chk("midrst_data", 32'(o_data), 0);
        chk("midrst_len_err", 32'(o_err), 1);

        // Randomized scan episodes
        for (int e = 0; e < 80; e++) begin
            fdi = 3'($urandom);
            r8 = int'($urandom_range(0, 7));
            n = (r8 < 4) ? 5 : (r8 == 4) ? 4 : (r8 == 5) ? 6 : int'($urandom_range(0, 8));
            cyc(1, 1, 1, 1'($urandom), 1'($urandom), 1'($urandom));
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 9) == 0)
                    cyc(1, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                sh(1'($urandom));
            end
            if ($urandom_range(0, 15) == 0)
                cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 9) == 0)
                cyc(1, 1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            up();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
